// File: rtl/sar_controller.sv
// Successive-approximation sequencer: sample phase, then N bit trials
// driving the DAC, then a one-cycle valid strobe with the final code.
module sar_controller #(
  parameter int N             = 8,
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         start,
  input  logic         comp_in,
  output logic         sample_en,
  output logic [N-1:0] dac_code,
  output logic         busy,
  output logic [N-1:0] result,
  output logic         valid
);

  localparam int SW = $clog2(SAMPLE_CYCLES + 1);
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    DONE
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [N-1:0]   dac_q, dac_d;
  logic [N-1:0]   res_q, res_d;
  logic           se_q, se_d;
  logic           busy_q, busy_d;
  logic           valid_q, valid_d;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      dac_q   <= '0;
      res_q   <= '0;
      se_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dac_q   <= dac_d;
      res_q   <= res_d;
      se_q    <= se_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dac_d   = dac_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          cnt_d   = SW'(SAMPLE_CYCLES - 1);
          dac_d   = '0;
        end
      end
      SAMPLE: begin
        if (cnt_q == '0) begin
          state_d = CONVERT;
          dac_d   = N'(1) << (N - 1);
          idx_d   = IW'(N - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      CONVERT: begin
        // Resolve bit i, then raise the next lower trial bit
        dac_d[idx_q] = comp_in;
        if (idx_q != '0) begin
          dac_d[idx_q - 1'b1] = 1'b1;
          idx_d = idx_q - 1'b1;
        end else begin
          state_d = DONE;
          res_d   = {dac_q[N-1:1], comp_in};
        end
      end
      DONE: begin
        dac_d = '0;
        if (start) begin
          state_d = SAMPLE;
          cnt_d   = SW'(SAMPLE_CYCLES - 1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status flags are registered from the next state
  always_comb begin
    se_d    = (state_d == SAMPLE);
    busy_d  = (state_d != IDLE);
    valid_d = (state_d == DONE);
  end

  assign sample_en = se_q;
  assign dac_code  = dac_q;
  assign busy      = busy_q;
  assign result    = res_q;
  assign valid     = valid_q;

endmodule

// File: doc/sar_controller.md
# sar_controller

Successive-approximation sequencer for the tiny-SAR ADC. It owns the conversion timeline: it runs a sample (track) phase, then N bit-trial cycles. In each trial it drives a trial code to the capacitive DAC and resolves one bit from the comparator. It presents the final code with a one-cycle valid strobe. It sits between the system-level conversion request and the analog front end (sample switch, DAC, comparator), and runs on the same fast clock that the bit-cycle clock is derived from.

## Interface
- N, 8: resolution in bits; legal range 2..16.
- SAMPLE_CYCLES, 2: number of clk_in cycles that sample_en is held high; legal range 1..255.

Ports:
- clk_in  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- start  input  1  conversion request, level-sampled in IDLE and DONE only.
- comp_in  input  1  comparator decision for the current dac_code; 1 = Vin >= Vdac, keep the trial bit.
- sample_en  output  1  closes the sampling switch; high during the SAMPLE state only.
- dac_code  output  N  trial code driven to the DAC.
- busy  output  1  high in SAMPLE, CONVERT and DONE.
- result  output  N  last completed conversion; holds until the next completion.
- valid  output  1  one-cycle strobe; result is updated in the same cycle.

## Operation
- States: IDLE, SAMPLE, CONVERT, DONE. All outputs are registered.
- Reset (rst=1 at an edge) forces IDLE with sample_en=0, dac_code=0, busy=0, result=0, valid=0. Reset has priority over every other event, including mid-conversion. An aborted conversion produces no valid and leaves result cleared.
- IDLE: if start=1, go to SAMPLE and load sample counter = SAMPLE_CYCLES-1.
- SAMPLE: sample_en=1, dac_code=0. Decrement the counter each cycle. When the counter is 0, go to CONVERT and load dac_code = 1<<(N-1), bit index = N-1.
- CONVERT, one trial per cycle, with i = bit index:
  - comp_in is sampled at the end of the cycle in which dac_code is stable.
  - Next dac_code[i] = comp_in. If i>0, next dac_code[i-1] = 1. Higher bits are unchanged.
  - If i>0, decrement i. If i==0, go to DONE and load result = {dac_code[N-1:1], comp_in}.
- DONE (one cycle): valid=1, and dac_code holds the final code.
  - If start=1, go directly to SAMPLE (back-to-back conversion, no IDLE cycle).
  - Otherwise go to IDLE and clear dac_code to 0.
- start is ignored in SAMPLE and CONVERT. No queuing: a request seen only during busy is lost.
- Counter widths: sample counter is $clog2(SAMPLE_CYCLES+1) bits; bit index is $clog2(N) bits. No arithmetic wraps in legal operation.

## Timing
- Let start=1 be sampled at edge k (in IDLE):
  - sample_en is high for cycles k+1 .. k+SAMPLE_CYCLES.
  - CONVERT occupies cycles k+SAMPLE_CYCLES+1 .. k+SAMPLE_CYCLES+N, with the MSB trial first.
  - valid is high and result is updated in cycle k+SAMPLE_CYCLES+N+1.
- Latency from start to valid is SAMPLE_CYCLES+N+1 cycles. With the defaults (SAMPLE_CYCLES=2, N=8) that is 11 cycles.
- Back-to-back throughput is one conversion every SAMPLE_CYCLES+N+1 cycles.
- comp_in must be settled one setup time before the edge ending each CONVERT cycle. The controller adds no extra settling cycle.
- busy rises the cycle after start is accepted and falls the cycle after DONE, unless DONE re-enters SAMPLE.
- valid is never high for two consecutive cycles.

## Test plan
- Nominal (N=8, S=2), with comparator model comp_in = (vin >= dac_code):
  - vin=0xA5, start pulse: dac_code sequence is 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - valid is high 11 cycles after the start edge, with result=0xA5.
- Extremes: vin=0x00 gives result 0x00 (dac_code 0x80, 0x40, ... 0x01). vin=0xFF gives result 0xFF. Both complete at exactly the same latency.
- Back-to-back: start held high, vin changing 0x3C then 0xC3.
  - Two valid strobes 11 cycles apart, with results 0x3C and 0xC3.
  - sample_en high exactly 2 cycles each time.
  - No IDLE cycle between the two conversions.
- Start while busy: start pulses in SAMPLE and mid-CONVERT are ignored. Exactly one valid appears, and latency is unchanged.
- Reset mid-conversion: assert rst at the 4th CONVERT cycle.
  - Next cycle shows IDLE outputs, including result=0.
  - No valid is produced.
  - A following start converts vin=0x5A correctly.
- Parameter sweep: (N=4, S=1) and (N=12, S=5) with random vin.
  - result == vin on every conversion.
  - Latency == S+N+1 every time.
